// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: parametrised synchronous FIFO controller.
// Uses all DEPTH entries. Each pointer carries an extra wrap bit, so full and
// empty can always be told apart.
// Features:
//   - a registered occupancy count
//   - programmable almost-full and almost-empty flags
//   - one-cycle overflow and underflow pulses
//   - a write on a full FIFO is accepted when a read is accepted in the same cycle
//   - a selectable first-word-fall-through (FWFT) read path
//
// Request/accept semantics:
//   - w_en and r_en are requests, not handshakes, and there is no ready output.
//   - A read is accepted when the FIFO is not empty.
//   - A write is accepted when the FIFO is not full, or when a read is accepted
//     in the same cycle.
//   - Both decisions use the state before the clock edge.
//   - A rejected request changes no state. Its only effect is a one-cycle
//     overflow or underflow pulse, seen the cycle after the request.
//   - A read on an empty FIFO never bypasses a write made in the same cycle.
module sync_fifo_ctl #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    // Address width and pointer width; the pointer MSB is the wrap bit.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] CNT_ZERO  = PW'(0);
    localparam logic [PW-1:0] CNT_FULL  = PW'(DEPTH);
    localparam logic [PW-1:0] CNT_AF    = PW'(AF_THRESH);
    localparam logic [PW-1:0] CNT_AE    = PW'(AE_THRESH);

    // Storage: never reset, so stale words survive a reset and are simply unreachable.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers, occupancy and error pulses.
    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // Accept decisions for this cycle.
    logic          rd_ok;
    logic          wr_ok;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;

    assign w_addr = w_ptr_q[AW-1:0];
    assign r_addr = r_ptr_q[AW-1:0];

    // Flags decode only the registered count, so they settle one cycle after the operation.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == CNT_ZERO);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept rules and next-state pointer, count and error values.
    always_comb begin
        rd_ok       = 1'b0;
        wr_ok       = 1'b0;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        rd_ok = r_en & ~empty;
        wr_ok = w_en & (~full | rd_ok);

        if (wr_ok) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            r_ptr_d = r_ptr_q + PTR_ONE;
        end

        // The pointer difference modulo 2*DEPTH is exactly the occupancy.
        count_d = w_ptr_d - r_ptr_d;

        overflow_d  = w_en & ~wr_ok;
        underflow_d = r_en & ~rd_ok;
    end

    // Pointer, count and error-pulse registers; reset wins over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Store accepted writes at the edge; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem_q[w_addr] <= in_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is shown directly. It is meaningless while empty.
            always_comb begin
                out_data = mem_q[r_addr];
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;

            // Registered read: the word arrives one cycle after an accepted read, otherwise held.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem_q[r_addr];
                end
            end

            assign out_data = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl.
// Instance u_std uses the registered read path; instance u_fwft uses fall-through.
// The final phase runs a seeded push/pop run with a mid-run reset, checked
// against an expected queue.
module tb_sync_fifo_ctl;

    localparam int DW = 16;
    localparam int CW = 4;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Standard-read instance signals.
    logic          s_w_en = 1'b0;
    logic          s_r_en = 1'b0;
    logic [DW-1:0] s_in   = '0;
    logic [DW-1:0] s_out;
    logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic [CW-1:0] s_count;

    // FWFT instance signals.
    logic          f_w_en = 1'b0;
    logic          f_r_en = 1'b0;
    logic [DW-1:0] f_in   = '0;
    logic [DW-1:0] f_out;
    logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [CW-1:0] f_count;

    sync_fifo_ctl #(.DEPTH(8), .DATA_WIDTH(DW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .w_en(s_w_en), .r_en(s_r_en), .in_data(s_in),
        .out_data(s_out), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_ctl #(.DEPTH(8), .DATA_WIDTH(DW), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .r_en(f_r_en), .in_data(f_in),
        .out_data(f_out), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_un)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard state for the push/pop run.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_out;

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_std_flags(input string tag, input int cnt, input logic e, input logic f,
                                 input logic ae, input logic af);
        chk({tag, "_count"}, 32'(s_count), 32'(cnt));
        chk({tag, "_empty"}, 32'(s_empty), 32'(e));
        chk({tag, "_full"},  32'(s_full),  32'(f));
        chk({tag, "_ae"},    32'(s_ae),    32'(ae));
        chk({tag, "_af"},    32'(s_af),    32'(af));
    endtask

    initial begin
        // ---- reset, then idle ----
        rst = 1'b1;
        s_w_en = 1'b1;  // reset must win over requests
        s_in   = 16'hDEAD;
        step();
        step();
        rst = 1'b0;
        s_w_en = 1'b0;
        step();
        chk_std_flags("rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_ov",  32'(s_ov),  32'h0);
        chk("rst_un",  32'(s_un),  32'h0);
        chk("rst_out", 32'(s_out), 32'h0);
        chk("rst_f_empty", 32'(f_empty), 32'h1);

        // ---- fill 0x0001..0x0008 ----
        s_w_en = 1'b1;
        s_in   = 16'h0001; step(); chk_std_flags("w1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        s_in   = 16'h0002; step(); chk_std_flags("w2", 2, 1'b0, 1'b0, 1'b1, 1'b0);
        s_in   = 16'h0003; step(); chk_std_flags("w3", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        s_in   = 16'h0004; step(); chk_std_flags("w4", 4, 1'b0, 1'b0, 1'b0, 1'b0);
        s_in   = 16'h0005; step(); chk_std_flags("w5", 5, 1'b0, 1'b0, 1'b0, 1'b0);
        s_in   = 16'h0006; step(); chk_std_flags("w6", 6, 1'b0, 1'b0, 1'b0, 1'b1);
        s_in   = 16'h0007; step(); chk_std_flags("w7", 7, 1'b0, 1'b0, 1'b0, 1'b1);
        s_in   = 16'h0008; step(); chk_std_flags("w8", 8, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("w8_ov", 32'(s_ov), 32'h0);

        // ---- 9th write on full: overflow pulse, nothing stored ----
        s_in = 16'h0099;
        step();
        chk("ovf_pulse", 32'(s_ov),    32'h1);
        chk("ovf_count", 32'(s_count), 32'h8);
        chk("ovf_full",  32'(s_full),  32'h1);
        s_w_en = 1'b0;
        step();
        chk("ovf_clear", 32'(s_ov),    32'h0);
        chk("ovf_hold",  32'(s_count), 32'h8);

        // ---- simultaneous write/read on full ----
        s_w_en = 1'b1;
        s_r_en = 1'b1;
        s_in   = 16'h00AA;
        step();
        chk("pt_out",   32'(s_out),   32'h0001);
        chk("pt_count", 32'(s_count), 32'h8);
        chk("pt_ov",    32'(s_ov),    32'h0);
        chk("pt_un",    32'(s_un),    32'h0);

        // ---- drain: 0x0002..0x0008 then 0x00AA ----
        s_w_en = 1'b0;
        step(); chk("d2", 32'(s_out), 32'h0002);
        step(); chk("d3", 32'(s_out), 32'h0003);
        step(); chk("d4", 32'(s_out), 32'h0004);
        step(); chk("d5", 32'(s_out), 32'h0005);
        step(); chk("d6", 32'(s_out), 32'h0006);
        step(); chk("d7", 32'(s_out), 32'h0007);
        step(); chk("d8", 32'(s_out), 32'h0008);
        step(); chk("dAA", 32'(s_out), 32'h00AA);
        chk_std_flags("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // ---- read on empty: underflow pulse, out_data held ----
        step();
        chk("unf_pulse", 32'(s_un),  32'h1);
        chk("unf_out",   32'(s_out), 32'h00AA);
        s_r_en = 1'b0;
        step();
        chk("unf_clear", 32'(s_un),  32'h0);
        chk("unf_hold",  32'(s_out), 32'h00AA);

        // ---- simultaneous write/read on empty: no bypass ----
        s_w_en = 1'b1;
        s_r_en = 1'b1;
        s_in   = 16'h0055;
        step();
        chk("nb_un",    32'(s_un),    32'h1);
        chk("nb_count", 32'(s_count), 32'h1);
        chk("nb_out",   32'(s_out),   32'h00AA);
        s_w_en = 1'b0;
        step();
        chk("nb_read",  32'(s_out),   32'h0055);
        chk("nb_cnt0",  32'(s_count), 32'h0);
        chk("nb_un0",   32'(s_un),    32'h0);
        s_r_en = 1'b0;

        // ---- FWFT instance ----
        f_w_en = 1'b1;
        f_in   = 16'h1234;
        step();
        f_w_en = 1'b0;
        chk("fw_empty", 32'(f_empty), 32'h0);
        chk("fw_out",   32'(f_out),   32'h1234);
        chk("fw_count", 32'(f_count), 32'h1);
        step();
        chk("fw_hold",  32'(f_out),   32'h1234);
        f_r_en = 1'b1;
        step();
        f_r_en = 1'b0;
        chk("fw_pop_count", 32'(f_count), 32'h0);
        chk("fw_pop_empty", 32'(f_empty), 32'h1);
        chk("fw_pop_un",    32'(f_un),    32'h0);

        // ---- push/pop run with reset at cycle 100 ----
        exp_q.delete();
        exp_out = 16'h0055;
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic w, r, rd_ok, wr_ok;
            logic [DW-1:0] d;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            d = 16'($urandom_range(0, 16'hFFFF));
            s_w_en = w;
            s_r_en = r;
            s_in   = d;
            if (cyc == 100) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                exp_q.delete();
                exp_out = '0;
                chk("mid_rst_count", 32'(s_count), 32'h0);
                chk("mid_rst_empty", 32'(s_empty), 32'h1);
                chk("mid_rst_out",   32'(s_out),   32'h0);
                chk("mid_rst_ov",    32'(s_ov),    32'h0);
                chk("mid_rst_un",    32'(s_un),    32'h0);
            end else begin
                rd_ok = r && (exp_q.size() != 0);
                wr_ok = w && ((exp_q.size() != 8) || rd_ok);
                step();
                if (rd_ok) exp_out = exp_q.pop_front();
                if (wr_ok) exp_q.push_back(d);
                chk("rnd_out",   32'(s_out),   32'(exp_out));
                chk("rnd_count", 32'(s_count), 32'(exp_q.size()));
                chk("rnd_ov",    32'(s_ov),    32'(w && !wr_ok));
                chk("rnd_un",    32'(s_un),    32'(r && !rd_ok));
            end
        end
        s_w_en = 1'b0;
        s_r_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
- Parametrised synchronous FIFO for the datapath buffering layer; successor to the basic pointer-compare FIFO.
- Uses all DEPTH entries, with an extra pointer wrap bit so that full and empty are unambiguous.
- Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, pass-through on a full FIFO, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages that need back-pressure hints before hard full.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- DATA_WIDTH, 16, word width in bits.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- w_en  input  1  write request.
- r_en  input  1  read request.
- in_data  input  DATA_WIDTH  write data.
- out_data  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst high at a clk edge):
  - w_ptr, r_ptr and count go to 0.
  - out_data goes to 0 when FWFT=0.
  - overflow and underflow go to 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared.
  - Reset wins over any w_en/r_en in the same cycle; a reset mid-operation discards all stored data.
- Pointers:
  - w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide; the low bits address memory and the MSB is the wrap bit.
  - Each pointer increments modulo 2*DEPTH.
  - count = w_ptr - r_ptr, kept as a register updated each cycle.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the count register only.
  - They are therefore valid the cycle after the causing operation.
- Accept rules, evaluated on the pre-edge state:
  - rd_ok = r_en & !empty.
  - wr_ok = w_en & (!full | rd_ok). A write on a full FIFO is accepted when a read is accepted in the same cycle.
  - A read on an empty FIFO is always rejected, even with a simultaneous write; there is no bypass.
- Count update:
  - +1 for wr_ok only.
  - -1 for rd_ok only.
  - Unchanged when both or neither are accepted.
- Errors:
  - overflow is registered and asserts for exactly one cycle after w_en & !wr_ok.
  - underflow is registered and asserts for exactly one cycle after r_en & !rd_ok.
  - A rejected request changes no state other than the error pulse.
- FWFT=0 read path:
  - On rd_ok, out_data <= mem[r_ptr], so data appears 1 cycle after the request.
  - out_data holds its value otherwise, including on a rejected read.
- FWFT=1 read path:
  - out_data = mem[r_ptr] combinationally; the head word is visible whenever empty=0.
  - r_en pops the head.
  - out_data is don't-care while empty=1.
  - A written word becomes visible the cycle after its write edge.
- Write path: on wr_ok, mem[w_ptr] <= in_data, so the word is stored at the edge.
- Ordering: strict FIFO order is preserved across pointer wrap-around for any number of wraps.

Test Plan:
- Reset, then idle → count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0, out_data=0.
- DEPTH=8: write 0x0001..0x0008 on consecutive cycles →
  - count steps 1..8;
  - almost_full rises after the 6th write;
  - almost_empty falls after the 3rd write;
  - full=1 after the 8th write.
  - A 9th write with r_en=0 → overflow pulse; count stays 8; data unchanged.
- From full, w_en=r_en=1 with in_data=0x00AA →
  - FWFT=0: out_data=0x0001 next cycle;
  - count stays 8;
  - no overflow;
  - drain yields 0x0002..0x0008 then 0x00AA.
- From empty, w_en=r_en=1 with in_data=0x0055 →
  - underflow pulse, write accepted, count=1;
  - the next read returns 0x0055.
- FWFT=1: write 0x1234 into empty → next cycle empty=0 and out_data=0x1234 without r_en; r_en=1 → count=0, empty=1.
- Random push/pop for 200 cycles, including more than 3 pointer wraps, with rst asserted at cycle 100 → scoreboard matches order; all state clears after reset, with count=0 the cycle after.
